// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline latch with valid/ready handshake, one-entry skid
// buffer, flush, and a counter of non-zero words loaded into the output registers.
module pipe_stage_skid #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_WIDTH = 6,
  parameter int STAGE       = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  output logic                   out_valid,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic                   skid_full,
  output logic [CNT_WIDTH-1:0]   inst_cnt
);

  if (STAGE + 1 >= STALL_WIDTH) begin : g_bad_stage
    $error("pipe_stage_skid: STAGE+1 must be below STALL_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Handshake: a word transfers on a posedge when in_valid && in_ready && !up
  // (and no flush). in_ready depends only on skid occupancy, never on in_valid.
  logic up, dn, acc;
  logic unused_stall;

  logic [ADDR_WIDTH-1:0] skid_pc, skid_pc_nxt, pc_nxt;
  logic [DATA_WIDTH-1:0] skid_inst, skid_inst_nxt, inst_nxt;
  logic                  skid_full_nxt, out_valid_nxt, load_valid;
  logic [CNT_WIDTH-1:0]  inst_cnt_nxt;

  assign up           = stall[STAGE];
  assign dn           = stall[STAGE+1];
  assign unused_stall = ^stall;
  assign in_ready     = !skid_full;
  assign acc          = in_valid && in_ready && !up;

  always_comb begin
    pc_nxt        = pc_o;
    inst_nxt      = inst_o;
    out_valid_nxt = out_valid;
    skid_pc_nxt   = skid_pc;
    skid_inst_nxt = skid_inst;
    skid_full_nxt = skid_full;
    load_valid    = 1'b0;

    if (flush) begin
      pc_nxt        = '0;
      inst_nxt      = '0;
      out_valid_nxt = 1'b0;
      skid_pc_nxt   = '0;
      skid_inst_nxt = '0;
      skid_full_nxt = 1'b0;
    end else if (dn) begin
      // Output holds; a late-arriving word parks in the skid.
      if (acc) begin
        skid_pc_nxt   = pc_i;
        skid_inst_nxt = inst_i;
        skid_full_nxt = 1'b1;
      end
    end else if (skid_full) begin
      // Skid drains first, even under an upstream stall, to keep order.
      pc_nxt        = skid_pc;
      inst_nxt      = skid_inst;
      out_valid_nxt = 1'b1;
      skid_full_nxt = 1'b0;
      load_valid    = 1'b1;
    end else if (up) begin
      pc_nxt        = '0;
      inst_nxt      = '0;
      out_valid_nxt = 1'b0;
    end else begin
      pc_nxt        = in_valid ? pc_i : '0;
      inst_nxt      = in_valid ? inst_i : '0;
      out_valid_nxt = in_valid;
      load_valid    = in_valid;
    end

    inst_cnt_nxt = inst_cnt;
    if (load_valid && (inst_nxt != '0)) inst_cnt_nxt = inst_cnt + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_o      <= '0;
      inst_o    <= '0;
      out_valid <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_full <= 1'b0;
      inst_cnt  <= '0;
    end else begin
      pc_o      <= pc_nxt;
      inst_o    <= inst_nxt;
      out_valid <= out_valid_nxt;
      skid_pc   <= skid_pc_nxt;
      skid_inst <= skid_inst_nxt;
      skid_full <= skid_full_nxt;
      inst_cnt  <= inst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, counter wrap, randomized ordering
// scoreboard and asynchronous reset with the skid occupied.
module tb_pipe_stage_skid;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 6;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [SW-1:0] stall;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] inst_i;
  logic          out_valid;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] inst_o;
  logic          skid_full;
  logic [CW-1:0] inst_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_WIDTH(SW), .STAGE(1), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .out_valid(out_valid), .pc_o(pc_o), .inst_o(inst_o),
    .skid_full(skid_full), .inst_cnt(inst_cnt)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic up, input logic dn, input logic fl,
                       input logic iv, input logic [AW-1:0] pc, input logic [DW-1:0] inst);
    stall    = '0;
    stall[1] = up;
    stall[2] = dn;
    flush    = fl;
    in_valid = iv;
    pc_i     = pc;
    inst_i   = inst;
  endtask

  typedef struct {
    logic          up, dn, fl, iv;
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic          e_ov;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_inst;
    logic          e_sf;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];

  initial begin
    logic          up, dn, have_word, m_skid, accd;
    logic [AW-1:0] w_pc;
    logic [DW-1:0] w_inst;
    logic [AW+DW-1:0] e;
    logic [CW-1:0] m_cnt;

    //            up  dn  fl  iv  pc     inst     ov  pc_o   inst_o  sf  cnt
    vecs[0]  = '{0,  0,  0,  1,  'h00,  'h13,    1,  'h00,  'h13,   0,  1};
    vecs[1]  = '{0,  0,  0,  1,  'h04,  'h93,    1,  'h04,  'h93,   0,  2};
    vecs[2]  = '{0,  0,  0,  1,  'h08,  'h113,   1,  'h08,  'h113,  0,  3};
    vecs[3]  = '{0,  1,  0,  1,  'h10,  'hAB,    1,  'h08,  'h113,  1,  3};
    vecs[4]  = '{0,  1,  0,  1,  'h14,  'h33,    1,  'h08,  'h113,  1,  3};
    vecs[5]  = '{0,  0,  0,  1,  'h14,  'h33,    1,  'h10,  'hAB,   0,  4};
    vecs[6]  = '{0,  0,  0,  1,  'h14,  'h33,    1,  'h14,  'h33,   0,  5};
    vecs[7]  = '{1,  0,  0,  1,  'h18,  'h55,    0,  'h00,  'h00,   0,  5};
    vecs[8]  = '{0,  0,  0,  0,  'h18,  'h55,    0,  'h00,  'h00,   0,  5};
    vecs[9]  = '{0,  0,  0,  1,  'h1C,  'h00,    1,  'h1C,  'h00,   0,  5};
    vecs[10] = '{0,  1,  0,  1,  'h20,  'h77,    1,  'h1C,  'h00,   1,  5};
    vecs[11] = '{0,  1,  1,  1,  'h24,  'h88,    0,  'h00,  'h00,   0,  5};
    vecs[12] = '{1,  1,  0,  1,  'h24,  'h88,    0,  'h00,  'h00,   0,  5};
    vecs[13] = '{0,  0,  0,  1,  'h24,  'h88,    1,  'h24,  'h88,   0,  6};
    vecs[14] = '{0,  1,  0,  1,  'h28,  'h99,    1,  'h24,  'h88,   1,  6};
    vecs[15] = '{1,  0,  0,  1,  'h2C,  'hAA,    1,  'h28,  'h99,   0,  7};
    vecs[16] = '{0,  0,  0,  1,  'h2C,  'hAA,    1,  'h2C,  'hAA,   0,  8};

    reset = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_inst_o", inst_o, 0);
    chk("rst_skid_full", skid_full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_inst_cnt", inst_cnt, 0);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].up, vecs[i].dn, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].inst);
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_pc_o", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_inst_o", i), inst_o, vecs[i].e_inst);
      chk($sformatf("v%0d_skid_full", i), skid_full, vecs[i].e_sf);
      chk($sformatf("v%0d_in_ready", i), in_ready, !vecs[i].e_sf);
      chk($sformatf("v%0d_inst_cnt", i), inst_cnt, vecs[i].e_cnt);
    end

    // counter wrap: 15 non-zero loads reach all-ones, one more wraps to 0
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 1, AW'(i * 4), DW'(i + 1));
      step();
    end
    chk("wrap_cnt_max", inst_cnt, 15);
    drive(0, 0, 0, 1, 'h100, 'h5);
    step();
    chk("wrap_cnt_zero", inst_cnt, 0);
    chk("wrap_inst_o", inst_o, 'h5);
    drive(0, 0, 0, 0, '0, '0);
    step();
    chk("bubble_valid", out_valid, 0);

    // randomized streaming with stalls; ordering and count checked by scoreboard
    m_skid    = 1'b0;
    m_cnt     = '0;
    have_word = 1'b0;
    w_pc      = '0;
    w_inst    = '0;
    for (int c = 0; c < 300; c++) begin
      up = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 2) == 0);
      if (!have_word && ($urandom_range(0, 3) != 0)) begin
        have_word = 1'b1;
        w_pc      = AW'($urandom);
        w_inst    = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      end
      drive(up, dn, 0, have_word, w_pc, w_inst);
      #1;
      chk("rnd_in_ready", in_ready, !m_skid);
      if (out_valid && !dn) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_pc_o", pc_o, e[AW+DW-1:DW]);
          chk("rnd_inst_o", inst_o, e[DW-1:0]);
          if (e[DW-1:0] != '0) m_cnt = m_cnt + 1'b1;
        end
      end
      accd = have_word && !m_skid && !up;
      if (accd) begin
        exp_q.push_back({w_pc, w_inst});
        have_word = 1'b0;
      end
      if (dn) begin
        if (accd) m_skid = 1'b1;
      end else begin
        m_skid = 1'b0;
      end
      step();
    end
    // drain with a bounded cycle budget
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0, '0, '0);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("drain_pc_o", pc_o, e[AW+DW-1:DW]);
          chk("drain_inst_o", inst_o, e[DW-1:0]);
          if (e[DW-1:0] != '0) m_cnt = m_cnt + 1'b1;
        end
      end
      step();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("rnd_inst_cnt", inst_cnt, m_cnt);

    // asynchronous reset between edges with the skid occupied
    drive(0, 0, 0, 1, 'h40, 'hC1);
    step();
    drive(0, 1, 0, 1, 'h44, 'hC2);
    step();
    chk("pre_arst_skid_full", skid_full, 1);
    chk("pre_arst_out_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_pc_o", pc_o, 0);
    chk("arst_inst_o", inst_o, 0);
    chk("arst_skid_full", skid_full, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_inst_cnt", inst_cnt, 0);
    drive(0, 0, 0, 0, '0, '0);
    step();
    reset = 1'b0;
    step();
    chk("post_arst_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
